ir_queue: RTL

IR_QUEUE -- requirements
Module: ir_queue

---
 rtl/ir_queue_if.sv | 28 ++
 rtl/ir_queue.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ir_queue_if.sv
// Instruction-queue bus: producer-side write port, consumer-side advance/increment and the decoded head word.
interface ir_queue_if #(
    parameter int N     = 17,
    parameter int OPW   = 5,
    parameter int ADW   = 12,
    parameter int DEPTH = 4
);
    logic                         write_en;
    logic [N-1:0]                 datain;
    logic                         advance;
    logic                         inc_en;
    logic                         flush;
    logic [ADW-1:0]               dataout;
    logic [OPW:0]                 instruction;
    logic                         valid;
    logic                         full;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output write_en, datain, advance, inc_en, flush,
        input  dataout, instruction, valid, full, count
    );

    modport slave (
        input  write_en, datain, advance, inc_en, flush,
        output dataout, instruction, valid, full, count
    );
endinterface

// File: rtl/ir_queue.sv
// Instruction register with a small FIFO behind it: the output stage holds the oldest word, decoded.
// Latency 1 cycle into an empty output stage; writes are dropped when full unless an advance frees a slot.
module ir_queue #(
    parameter int N     = 17,
    parameter int OPW   = 5,
    parameter int ADW   = 12,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    ir_queue_if.slave   bus
);
    localparam int QD = DEPTH - 1;
    localparam int PW = (QD > 1) ? $clog2(QD) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]   mem [QD];
    logic [PW-1:0]  rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CW-1:0]  cnt_q, cnt_nxt;
    logic [ADW-1:0] dout_q, dout_nxt;
    logic [OPW:0]   instr_q, instr_nxt;
    logic           vld_q, vld_nxt;
    logic           full_q, full_nxt;
    logic           eff_adv, acc_wr, push, pop, q_empty;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(QD - 1)) ? '0 : p + 1'b1;
    endfunction

    // The output stage counts toward cnt_q, so the storage queue is empty whenever cnt_q <= 1.
    assign q_empty = (cnt_q <= CW'(1));
    assign eff_adv = bus.advance & vld_q;
    assign acc_wr  = bus.write_en & (~full_q | eff_adv);

    always_comb begin
        rd_nxt    = rd_ptr;
        wr_nxt    = wr_ptr;
        cnt_nxt   = cnt_q;
        full_nxt  = full_q;
        dout_nxt  = dout_q;
        instr_nxt = instr_q;
        vld_nxt   = vld_q;
        push      = 1'b0;
        pop       = 1'b0;

        if (bus.flush) begin
            rd_nxt    = '0;
            wr_nxt    = '0;
            cnt_nxt   = '0;
            full_nxt  = 1'b0;
            dout_nxt  = '0;
            instr_nxt = '0;
            vld_nxt   = 1'b0;
        end else begin
            cnt_nxt  = cnt_q + CW'(acc_wr) - CW'(eff_adv);
            full_nxt = (cnt_nxt == CW'(DEPTH));

            if (eff_adv) begin
                if (!q_empty) begin
                    dout_nxt  = mem[rd_ptr][ADW-1:0];
                    instr_nxt = {1'b0, mem[rd_ptr][N-1:N-OPW]};
                    pop       = 1'b1;
                    push      = acc_wr;
                end else if (acc_wr) begin
                    dout_nxt  = bus.datain[ADW-1:0];
                    instr_nxt = {1'b0, bus.datain[N-1:N-OPW]};
                end else begin
                    // Operand and opcode deliberately keep their last values.
                    vld_nxt = 1'b0;
                end
            end else begin
                if (acc_wr) begin
                    if (!vld_q) begin
                        dout_nxt  = bus.datain[ADW-1:0];
                        instr_nxt = {1'b0, bus.datain[N-1:N-OPW]};
                        vld_nxt   = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                if (bus.inc_en && vld_q) begin
                    dout_nxt = dout_q + 1'b1;
                end
            end

            if (pop)  rd_nxt = wrap_inc(rd_ptr);
            if (push) wr_nxt = wrap_inc(wr_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.datain;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            dout_q  <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            rd_ptr  <= rd_nxt;
            wr_ptr  <= wr_nxt;
            cnt_q   <= cnt_nxt;
            full_q  <= full_nxt;
            dout_q  <= dout_nxt;
            instr_q <= instr_nxt;
            vld_q   <= vld_nxt;
        end
    end

    assign bus.dataout     = dout_q;
    assign bus.instruction = instr_q;
    assign bus.valid       = vld_q;
    assign bus.full        = full_q;
    assign bus.count       = cnt_q;
endmodule
